conv_tile_mover: RTL and testbench
==================================

# conv_tile_mover

Multi-tile successor to the single-pass convolution data mover: sequences weight-stationary loads and activation streaming between two single-port read memories, the systolic array and the GLB. One `start_i` runs `cfg_num_tiles` tiles. Each tile loads PE_SIZE weight rows from mem0, waits a settle gap, then streams `cfg_act_rows` activation vectors from mem1, rewound every tile. Adds start/busy/done handshake, runtime base addresses, GLB back-pressure stall and a clean drain.

## Interface
- PE_SIZE, 16: systolic array dimension; weight rows per tile.
- DATA_WIDTH, 128: memory word width, both memories.
- MEM0_ADDR_WIDTH, 10: weight memory address width.
- MEM1_ADDR_WIDTH, 10: activation memory address width.
- TILE_CNT_WIDTH, 8: width of the tile count.
- ROW_CNT_WIDTH, 11: width of the activation row count.
- LOAD_GAP, PE_SIZE-2: idle cycles between the last weight read and the first activation read; 0 allowed.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- cfg_num_tiles_i  in  TILE_CNT_WIDTH  tiles per run; latched on accepted start.
- cfg_act_rows_i  in  ROW_CNT_WIDTH  activation reads per tile; latched on accepted start.
- cfg_w_base_i  in  MEM0_ADDR_WIDTH  first weight address; latched on accepted start.
- cfg_a_base_i  in  MEM1_ADDR_WIDTH  first activation address; latched on accepted start.
- stall_i  in  1  GLB back-pressure; pauses streaming.
- mem0_q0_i / mem1_q0_i  in  DATA_WIDTH  memory read data, 1-cycle latency.
- mem0_addr0 / mem1_addr0  out  MEM*_ADDR_WIDTH  read addresses.
- mem0_ce0 / mem1_ce0  out  1  chip enables.
- mem0_we0 / mem1_we0  out  1  tied 0.
- mem0_q0_o  out  DATA_WIDTH  weight data to SA; equals mem0_q0_i.
- mem0_q0_valid_o  out  1  weight data valid.
- mem1_q0_o  out  DATA_WIDTH  activation data to GLB; equals mem1_q0_i.
- wren_o / rden_o  out  1  GLB write / read enables.
- tile_idx_o  out  TILE_CNT_WIDTH  current tile index.
- busy_o / done_o  out  1  run active / one-cycle completion pulse.

## Operation
- FSM states IDLE, LOAD_W, GAP, STREAM, DRAIN, DONE.
- IDLE: start_i=1 latches the cfg fields, sets w_addr=cfg_w_base, tile=0. Go to LOAD_W; if cfg_num_tiles=0, go to DONE.
- LOAD_W: mem0_ce0=1 for exactly PE_SIZE cycles; w_addr +1 per cycle. It is never reset between tiles, so tile t reads w_base+t*PE_SIZE+r, modulo 2^MEM0_ADDR_WIDTH.
- After LOAD_W: go to GAP if LOAD_GAP>0, else STREAM. GAP lasts LOAD_GAP cycles with both ce low.
- STREAM entry: a_addr=cfg_a_base. mem1_ce0 = !stall_i. a_addr and the row counter advance only on cycles with ce=1. Exit after cfg_act_rows issued reads; cfg_act_rows=0 skips STREAM.
- End of tile: if tile+1<cfg_num_tiles, increment tile and go to LOAD_W; otherwise go to DRAIN (2 cycles), then DONE (1 cycle, done_o=1), then IDLE.
- busy_o=1 in every state except IDLE.
- start_i outside IDLE is ignored.
- stall_i outside STREAM has no effect.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pipeline registers 0.
- Reset asserted mid-run aborts immediately. No done_o pulse.
- mem0_ce0 and mem1_ce0 are decoded from registered state and counters plus stall_i. No registered ce lag.
- Start sampled at edge k: first mem0_ce0 in cycle k+1.
- mem0_q0_valid_o = mem0_ce0 delayed 1 cycle.
- wren_o = mem1_ce0 delayed 1 cycle; rden_o = wren_o delayed 1 cycle.
- DRAIN guarantees the last rden_o falls before done_o rises.
- Per-tile cycle count, no stall: PE_SIZE + LOAD_GAP + cfg_act_rows.
- Run length = tiles × per-tile count + 3 (DRAIN + DONE) cycles after the first ce.

## Structure
- Shared package `conv_mover_pkg`: state enum encoding, default PE_SIZE/DATA_WIDTH, clog2-derived counter widths.
- One sub-module, `mover_delay_line` (parametrised depth, 1-bit, async active-high reset). Used for the valid/wren/rden pipeline.

## Test plan
- PE_SIZE=4, LOAD_GAP=2, tiles=1, rows=3, w_base=0x10, a_base=0x20. Expect mem0 addresses 0x10–0x13 in cycles 1–4, gap cycles 5–6, mem1 addresses 0x20–0x22 in cycles 7–9, done_o in cycle 12.
- Same settings, tiles=3. Expect weight addresses 0x10–0x1B contiguous and activation addresses 0x20–0x22 repeated three times. tile_idx_o steps 0→1→2. One done_o pulse.
- stall_i high for 2 cycles mid-STREAM. Expect mem1_ce0 low and address held during the stall. wren_o gap delayed 1 cycle. Every row read exactly once.
- tiles=0 → done_o one cycle after start, no ce. rows=0 → LOAD_W/GAP only per tile.
- start_i pulsed during STREAM → ignored. rst pulsed mid-LOAD_W → all outputs 0 next cycle, no done_o. A new start then runs normally.
- w_base=max-1 with MEM0_ADDR_WIDTH=4 → weight addresses 0xE, 0xF, 0x0, 0x1 (wrap).

Source files
------------

// File: rtl/conv_mover_pkg.sv
// conv_mover_pkg: shared state encoding, default sizes and counter-width helper for the tile mover
package conv_mover_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_GAP, S_STREAM, S_DRAIN, S_DONE} state_e;
  localparam int PE_SIZE_DEF = 16;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int ROW_CNT_WIDTH_DEF = 11;
  // One counter serves weight rows, gap cycles, activation rows and drain.
  function automatic int cnt_width(int pe, int gap, int row_w);
    int w;
    w = $clog2((pe > gap ? pe : gap) + 1);
    return (w > row_w) ? w : row_w;
  endfunction
endpackage

// File: rtl/mover_delay_line.sv
// mover_delay_line: 1-bit shift register of configurable depth with async reset
module mover_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr_q <= '0;
    else sr_q <= DEPTH'({sr_q, d_i});
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/conv_tile_mover.sv
// conv_tile_mover: multi-tile weight-load / activation-stream sequencer for the systolic array
module conv_tile_mover
  import conv_mover_pkg::*;
#(
  parameter int PE_SIZE         = PE_SIZE_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int MEM0_ADDR_WIDTH = 10,
  parameter int MEM1_ADDR_WIDTH = 10,
  parameter int TILE_CNT_WIDTH  = 8,
  parameter int ROW_CNT_WIDTH   = ROW_CNT_WIDTH_DEF,
  parameter int LOAD_GAP        = PE_SIZE - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [TILE_CNT_WIDTH-1:0]  cfg_num_tiles_i,
  input  logic [ROW_CNT_WIDTH-1:0]   cfg_act_rows_i,
  input  logic [MEM0_ADDR_WIDTH-1:0] cfg_w_base_i,
  input  logic [MEM1_ADDR_WIDTH-1:0] cfg_a_base_i,
  input  logic                       stall_i,
  input  logic [DATA_WIDTH-1:0]      mem0_q0_i,
  input  logic [DATA_WIDTH-1:0]      mem1_q0_i,
  output logic [MEM0_ADDR_WIDTH-1:0] mem0_addr0,
  output logic                       mem0_ce0,
  output logic                       mem0_we0,
  output logic [MEM1_ADDR_WIDTH-1:0] mem1_addr0,
  output logic                       mem1_ce0,
  output logic                       mem1_we0,
  output logic [DATA_WIDTH-1:0]      mem0_q0_o,
  output logic                       mem0_q0_valid_o,
  output logic [DATA_WIDTH-1:0]      mem1_q0_o,
  output logic                       wren_o,
  output logic                       rden_o,
  output logic [TILE_CNT_WIDTH-1:0]  tile_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int CW = cnt_width(PE_SIZE, LOAD_GAP, ROW_CNT_WIDTH);
  state_e                     state_q;
  logic [CW-1:0]              cnt_q;
  logic [TILE_CNT_WIDTH-1:0]  tiles_q, tile_q;
  logic [ROW_CNT_WIDTH-1:0]   rows_q;
  logic [MEM0_ADDR_WIDTH-1:0] w_addr_q;
  logic [MEM1_ADDR_WIDTH-1:0] a_base_q, a_addr_q;
  logic load_end, gap_end, row_end, no_rows, last_tile, w_done, tile_end;
  assign load_end  = cnt_q == CW'(PE_SIZE - 1);
  assign gap_end   = cnt_q == CW'(LOAD_GAP - 1);
  assign row_end   = cnt_q == CW'(rows_q - 1'b1);
  assign no_rows   = rows_q == '0;
  assign last_tile = tile_q == tiles_q - 1'b1;
  assign w_done    = (state_q == S_LOAD_W && load_end && LOAD_GAP == 0) || (state_q == S_GAP && gap_end);
  assign tile_end  = (w_done && no_rows) || (state_q == S_STREAM && !stall_i && row_end);
  // Tile-boundary transitions are applied after the per-state updates so they take priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tiles_q  <= '0;
      tile_q   <= '0;
      rows_q   <= '0;
      w_addr_q <= '0;
      a_base_q <= '0;
      a_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          tiles_q  <= cfg_num_tiles_i;
          rows_q   <= cfg_act_rows_i;
          w_addr_q <= cfg_w_base_i;
          a_base_q <= cfg_a_base_i;
          tile_q   <= '0;
          cnt_q    <= '0;
          state_q  <= cfg_num_tiles_i == '0 ? S_DONE : S_LOAD_W;
        end
        S_LOAD_W: begin
          w_addr_q <= w_addr_q + 1'b1;
          cnt_q    <= load_end ? '0 : cnt_q + 1'b1;
          if (load_end && LOAD_GAP > 0) state_q <= S_GAP;
        end
        S_GAP: cnt_q <= gap_end ? '0 : cnt_q + 1'b1;
        S_STREAM: if (!stall_i) begin
          a_addr_q <= a_addr_q + 1'b1;
          cnt_q    <= row_end ? '0 : cnt_q + 1'b1;
        end
        S_DRAIN: begin
          cnt_q <= cnt_q == CW'(1) ? '0 : cnt_q + 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (w_done && !no_rows) begin
        state_q  <= S_STREAM;
        a_addr_q <= a_base_q;
      end
      if (tile_end) begin
        state_q <= last_tile ? S_DRAIN : S_LOAD_W;
        tile_q  <= last_tile ? tile_q : tile_q + 1'b1;
      end
    end
  end
  assign mem0_ce0   = state_q == S_LOAD_W;
  assign mem1_ce0   = state_q == S_STREAM && !stall_i;
  assign mem0_addr0 = w_addr_q;
  assign mem1_addr0 = a_addr_q;
  assign mem0_we0   = 1'b0;
  assign mem1_we0   = 1'b0;
  assign mem0_q0_o  = mem0_q0_i;
  assign mem1_q0_o  = mem1_q0_i;
  assign tile_idx_o = tile_q;
  assign busy_o     = state_q != S_IDLE;
  assign done_o     = state_q == S_DONE;
  mover_delay_line #(.DEPTH(1)) u_valid (.clk(clk), .rst(rst), .d_i(mem0_ce0), .q_o(mem0_q0_valid_o));
  mover_delay_line #(.DEPTH(1)) u_wren  (.clk(clk), .rst(rst), .d_i(mem1_ce0), .q_o(wren_o));
  mover_delay_line #(.DEPTH(1)) u_rden  (.clk(clk), .rst(rst), .d_i(wren_o),   .q_o(rden_o));
endmodule

// File: tb/tb_conv_tile_mover.sv
// tb_conv_tile_mover: table-driven runs with address/data scoreboards plus reset and wrap sequences
module tb_conv_tile_mover;
  localparam int DW = 16;
  typedef struct {
    int tiles;
    int rows;
    int wb;
    int ab;
    int stall_at;
    int start_at;
    int exp_done;
  } vec_t;
  logic clk = 0, rst = 1, start_i = 0, stall_i = 0, start2 = 0;
  logic [7:0] tiles_i = 0;
  logic [10:0] rows_i = 0;
  logic [9:0] wb_i = 0, ab_i = 0;
  logic [3:0] wb2 = 0;
  logic [DW-1:0] m0_d = 0, m1_d = 0, m0_d2 = 0;
  logic [9:0] m0_addr, m1_addr, m1_addr2;
  logic [3:0] m0_addr2;
  logic m0_ce, m0_we, m1_ce, m1_we, m0_valid, wren_o, rden_o, busy_o, done_o;
  logic m0_ce2, m0_we2, m1_ce2, m1_we2, m0_valid2, wren2, rden2, busy2, done2;
  logic [DW-1:0] m0_q, m1_q, m0_q2, m1_q2;
  logic [7:0] tile_idx, tile_idx2;
  int total = 0, passed = 0;
  vec_t tbl[7];
  logic [9:0] exp_w[$], exp_a[$];
  int exp_t[$];
  logic [DW-1:0] exp_wd[$], exp_ad[$];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    m0_d <= {6'h2A, m0_addr};
    m1_d <= {6'h15, m1_addr};
  end

  conv_tile_mover #(.PE_SIZE(4), .DATA_WIDTH(DW), .MEM0_ADDR_WIDTH(10), .MEM1_ADDR_WIDTH(10),
    .TILE_CNT_WIDTH(8), .ROW_CNT_WIDTH(11), .LOAD_GAP(2)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_num_tiles_i(tiles_i), .cfg_act_rows_i(rows_i),
    .cfg_w_base_i(wb_i), .cfg_a_base_i(ab_i), .stall_i(stall_i), .mem0_q0_i(m0_d), .mem1_q0_i(m1_d),
    .mem0_addr0(m0_addr), .mem0_ce0(m0_ce), .mem0_we0(m0_we), .mem1_addr0(m1_addr), .mem1_ce0(m1_ce),
    .mem1_we0(m1_we), .mem0_q0_o(m0_q), .mem0_q0_valid_o(m0_valid), .mem1_q0_o(m1_q), .wren_o(wren_o),
    .rden_o(rden_o), .tile_idx_o(tile_idx), .busy_o(busy_o), .done_o(done_o));

  conv_tile_mover #(.PE_SIZE(4), .DATA_WIDTH(DW), .MEM0_ADDR_WIDTH(4), .MEM1_ADDR_WIDTH(10),
    .TILE_CNT_WIDTH(8), .ROW_CNT_WIDTH(11), .LOAD_GAP(2)) dut_wrap (
    .clk(clk), .rst(rst), .start_i(start2), .cfg_num_tiles_i(tiles_i), .cfg_act_rows_i(rows_i),
    .cfg_w_base_i(wb2), .cfg_a_base_i(ab_i), .stall_i(1'b0), .mem0_q0_i(m0_d2), .mem1_q0_i(m1_d),
    .mem0_addr0(m0_addr2), .mem0_ce0(m0_ce2), .mem0_we0(m0_we2), .mem1_addr0(m1_addr2), .mem1_ce0(m1_ce2),
    .mem1_we0(m1_we2), .mem0_q0_o(m0_q2), .mem0_q0_valid_o(m0_valid2), .mem1_q0_o(m1_q2), .wren_o(wren2),
    .rden_o(rden2), .tile_idx_o(tile_idx2), .busy_o(busy2), .done_o(done2));

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run(input vec_t v);
    int done_rel = -1, nrd = 0, last_rd = 0;
    exp_w.delete(); exp_a.delete(); exp_t.delete(); exp_wd.delete(); exp_ad.delete();
    for (int t = 0; t < v.tiles; t++) begin
      for (int r = 0; r < 4; r++) begin
        exp_w.push_back(10'(v.wb + t * 4 + r));
        exp_t.push_back(t);
      end
      for (int r = 0; r < v.rows; r++) exp_a.push_back(10'(v.ab + r));
    end
    tiles_i = 8'(v.tiles); rows_i = 11'(v.rows); wb_i = 10'(v.wb); ab_i = 10'(v.ab);
    @(posedge clk); #1 start_i = 1;
    for (int rel = 1; rel <= 200; rel++) begin
      @(posedge clk); #1;
      start_i = (rel == v.start_at);
      stall_i = v.stall_at != 0 && (rel == v.stall_at || rel == v.stall_at + 1);
      @(negedge clk);
      if (stall_i) chk("stall_ce", m1_ce, 0);
      if (m0_valid) chk("w_data", m0_q, exp_wd.size() ? exp_wd.pop_front() : 'x);
      if (m0_ce) begin
        if (exp_w.size() == 0) chk("w_extra_read", m0_addr, 'h3FFFF);
        else begin
          logic [9:0] a;
          a = exp_w.pop_front();
          chk("w_addr", m0_addr, a);
          chk("tile_idx", tile_idx, exp_t.pop_front());
          exp_wd.push_back({6'h2A, a});
        end
      end
      if (wren_o) chk("a_data", m1_q, exp_ad.size() ? exp_ad.pop_front() : 'x);
      if (m1_ce) begin
        if (exp_a.size() == 0) chk("a_extra_read", m1_addr, 'h3FFFF);
        else begin
          logic [9:0] a;
          a = exp_a.pop_front();
          chk("a_addr", m1_addr, a);
          exp_ad.push_back({6'h15, a});
        end
      end
      if (rden_o) begin nrd++; last_rd = rel; end
      if (done_o) begin done_rel = rel; break; end
    end
    start_i = 0; stall_i = 0;
    chk("done_cycle", done_rel, v.exp_done);
    chk("busy_at_done", busy_o, 1);
    chk("left_in_queues", exp_w.size() + exp_a.size() + exp_wd.size() + exp_ad.size(), 0);
    chk("rden_count", nrd, v.tiles * v.rows);
    if (nrd > 0) chk("rden_before_done", last_rd < done_rel, 1);
    @(posedge clk); #1; @(negedge clk);
    chk("done_one_cycle", done_o, 0);
    chk("idle_after_done", busy_o, 0);
  endtask

  initial begin
    logic [3:0] wexp[4];
    int seen, d;
    wexp = '{4'hE, 4'hF, 4'h0, 4'h1};
    tbl[0] = '{1, 3, 'h10, 'h20, 0, 0, 12};
    tbl[1] = '{3, 3, 'h10, 'h20, 0, 0, 30};
    tbl[2] = '{2, 0, 'h10, 'h20, 0, 0, 15};
    tbl[3] = '{0, 3, 'h10, 'h20, 0, 0, 1};
    tbl[4] = '{1, 5, 'h40, 'h80, 8, 0, 16};
    tbl[5] = '{2, 1, 'h3FE, 'h3FF, 0, 0, 17};
    tbl[6] = '{1, 3, 'h10, 'h20, 0, 8, 12};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {m0_ce, m1_ce, busy_o, done_o, m0_valid, wren_o, rden_o, m0_we, m1_we, tile_idx, m0_addr, m1_addr}, 0);
    rst = 0;
    foreach (tbl[i]) run(tbl[i]);
    // Abort in the middle of a weight load.
    tiles_i = 1; rows_i = 3; wb_i = 'h10; ab_i = 'h20;
    @(posedge clk); #1 start_i = 1;
    @(posedge clk); #1 start_i = 0;
    @(posedge clk); #1;
    chk("ce_before_abort", m0_ce, 1);
    rst = 1;
    #1;
    chk("abort_outputs", {m0_ce, m1_ce, busy_o, done_o, m0_valid, wren_o, rden_o, tile_idx, m0_addr, m1_addr}, 0);
    @(posedge clk); #1 rst = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o || busy_o) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    run(tbl[0]);
    // Weight address wrap on a 4-bit weight memory.
    tiles_i = 1; rows_i = 0; wb2 = 4'hE; d = -1;
    @(posedge clk); #1 start2 = 1;
    for (int rel = 1; rel <= 20; rel++) begin
      @(posedge clk); #1 start2 = 0;
      @(negedge clk);
      if (rel <= 4) begin
        chk("wrap_ce", m0_ce2, 1);
        chk("wrap_addr", m0_addr2, wexp[rel-1]);
      end
      if (done2) begin d = rel; break; end
    end
    chk("wrap_done_cycle", d, 9);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
